// File: rtl/moving_sum100.sv
// Running-window sum over the last N samples, fed by a newest sample and the
// matching N-deep delay line output. Also tracks the peak full-window sum.
module moving_sum100 #(
  parameter int W     = 32,
  parameter int N     = 100,
  parameter int ACC_W = 39,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [W-1:0]     in_new,
  input  logic signed [W-1:0]     in_old,
  input  logic                    clr,
  output logic signed [ACC_W-1:0] sum,
  output logic                    sum_valid,
  output logic signed [ACC_W-1:0] peak,
  output logic                    peak_valid,
  output logic                    dbg_state
);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N);

  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] peak_q;
  logic                    peak_valid_q;

  state_e                  state;
  logic signed [ACC_W-1:0] ext_new;
  logic signed [ACC_W-1:0] ext_old;
  logic signed [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0]        cnt_next;
  logic                    valid_next;

  // State is a pure decode of the fill counter; no separate state register.
  assign state = (cnt == CNT_FULL) ? RUN : FILL;

  assign ext_new = {{(ACC_W - W){in_new[W-1]}}, in_new};
  assign ext_old = {{(ACC_W - W){in_old[W-1]}}, in_old};

  // During FILL the delay line output is pre-window data and must be ignored.
  always_comb begin
    acc_next = acc;
    cnt_next = cnt;
    if (clr) begin
      acc_next = '0;
      cnt_next = '0;
    end else if (state == RUN) begin
      acc_next = acc + ext_new - ext_old;
      cnt_next = CNT_FULL;
    end else begin
      acc_next = acc + ext_new;
      cnt_next = cnt + CNT_W'(1);
    end
  end

  assign valid_next = (cnt_next == CNT_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc          <= '0;
      cnt          <= '0;
      peak_q       <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      acc <= acc_next;
      cnt <= cnt_next;
      if (clr) begin
        peak_q       <= '0;
        peak_valid_q <= 1'b0;
      end else if (valid_next) begin
        // Compare against the sum produced on this same edge.
        if (!peak_valid_q || (acc_next > peak_q)) begin
          peak_q <= acc_next;
        end
        peak_valid_q <= 1'b1;
      end
    end
  end

  assign sum        = acc;
  assign sum_valid  = (state == RUN);
  assign peak       = peak_q;
  assign peak_valid = peak_valid_q;
  assign dbg_state  = state;

endmodule
